// File: rtl/uart_rx_fifo_if.sv
// rtl/uart_rx_fifo_if.sv - control, serial line, FIFO read and status bundle for uart_rx_fifo
interface uart_rx_fifo_if #(
  parameter int DATA_BITS = 8,
  parameter int DEPTH     = 8
);
  logic                   en;
  logic [15:0]            prescale;
  logic                   rx;
  logic                   rd;
  logic [DATA_BITS-1:0]   rdata;
  logic                   empty;
  logic                   full;
  logic [$clog2(DEPTH):0] level;
  logic                   err_clr;
  logic                   frame_err;
  logic                   parity_err;
  logic                   overrun;

  modport master (
    output en, prescale, rx, rd, err_clr,
    input  rdata, empty, full, level, frame_err, parity_err, overrun
  );

  modport slave (
    input  en, prescale, rx, rd, err_clr,
    output rdata, empty, full, level, frame_err, parity_err, overrun
  );
endinterface

// File: rtl/uart_rx_fifo.sv
// rtl/uart_rx_fifo.sv - oversampling UART receiver feeding a first-word-fall-through FIFO
module uart_rx_fifo #(
  parameter int DATA_BITS = 8,
  parameter int PARITY    = 0,
  parameter int OVS       = 16,
  parameter int DEPTH     = 8
) (
  input  logic          HCLK,
  input  logic          HRESET,
  uart_rx_fifo_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int TW = $clog2(OVS);
  localparam int BW = 4;
  localparam logic [TW-1:0] HALF_LAST = TW'(OVS / 2 - 1);
  localparam logic [TW-1:0] FULL_LAST = TW'(OVS - 1);
  localparam logic [BW-1:0] BIT_LAST  = BW'(DATA_BITS - 1);
  localparam logic [AW:0]   FULL_LVL  = (AW + 1)'(DEPTH);

  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PAR, S_STOP, S_BREAK} state_t;
  state_t r_state, w_next;

  logic                 r_rx_s1, r_rx_s2, r_rx_d;
  logic [15:0]          r_presc;
  logic [TW-1:0]        r_tick_cnt;
  logic [BW-1:0]        r_bit_cnt;
  logic [DATA_BITS-1:0] r_shift;
  logic                 r_bad;
  logic                 w_fall, w_tick, w_sample_pt, w_sample, w_exp_par;
  logic                 w_push, w_set_fe, w_set_pe;

  logic [DATA_BITS-1:0] r_mem [DEPTH];
  logic [AW-1:0]        r_wptr, r_rptr;
  logic [AW:0]          r_level;
  logic                 r_fe, r_pe, r_ov;
  logic                 w_empty, w_full, w_pop, w_wr, w_ov;

  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      r_rx_s1 <= 1'b1;
      r_rx_s2 <= 1'b1;
      r_rx_d  <= 1'b1;
    end else begin
      r_rx_s1 <= bus.rx;
      r_rx_s2 <= r_rx_s1;
      r_rx_d  <= r_rx_s2;
    end
  end

  assign w_fall      = r_rx_d & ~r_rx_s2;
  assign w_tick      = (r_state != S_IDLE) && (r_presc == bus.prescale);
  assign w_sample_pt = (r_state == S_START) ? (r_tick_cnt == HALF_LAST) : (r_tick_cnt == FULL_LAST);
  assign w_sample    = w_tick & w_sample_pt;
  assign w_exp_par   = (PARITY == 2) ? ~(^r_shift) : (^r_shift);

  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next   = r_state;
    w_push   = 1'b0;
    w_set_fe = 1'b0;
    w_set_pe = 1'b0;
    unique case (r_state)
      S_IDLE:  if (bus.en && w_fall) w_next = S_START;
      S_START: if (w_sample) w_next = r_rx_s2 ? S_IDLE : S_DATA;
      S_DATA:  if (w_sample && (r_bit_cnt == BIT_LAST)) w_next = (PARITY != 0) ? S_PAR : S_STOP;
      S_PAR: if (w_sample) begin
        w_next   = S_STOP;
        w_set_pe = (r_rx_s2 != w_exp_par);
      end
      S_STOP: if (w_sample) begin
        if (!r_rx_s2) begin
          w_set_fe = 1'b1;
          w_next   = S_BREAK;
        end else begin
          w_push = ~r_bad;
          w_next = S_IDLE;
        end
      end
      S_BREAK: if (r_rx_s2) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
    // Disabling abandons the frame silently: no push and no error reporting.
    if (!bus.en) begin
      w_next   = S_IDLE;
      w_push   = 1'b0;
      w_set_fe = 1'b0;
      w_set_pe = 1'b0;
    end
  end

  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      r_presc    <= '0;
      r_tick_cnt <= '0;
      r_bit_cnt  <= '0;
      r_shift    <= '0;
      r_bad      <= 1'b0;
    end else if (r_state == S_IDLE) begin
      r_presc    <= '0;
      r_tick_cnt <= '0;
      r_bit_cnt  <= '0;
      r_bad      <= 1'b0;
    end else begin
      r_presc <= w_tick ? '0 : r_presc + 16'd1;
      if (w_tick) r_tick_cnt <= w_sample_pt ? '0 : r_tick_cnt + 1'b1;
      if (w_sample && (r_state == S_DATA)) begin
        r_shift   <= {r_rx_s2, r_shift[DATA_BITS-1:1]};
        r_bit_cnt <= r_bit_cnt + 1'b1;
      end
      if (w_set_pe) r_bad <= 1'b1;
    end
  end

  assign w_empty = (r_level == '0);
  assign w_full  = (r_level == FULL_LVL);
  assign w_pop   = bus.rd & ~w_empty;
  // A pop in the same cycle frees the slot the incoming word lands in.
  assign w_wr    = w_push & (~w_full | w_pop);
  assign w_ov    = w_push & w_full & ~w_pop;

  always_ff @(posedge HCLK) begin
    if (w_wr) r_mem[r_wptr] <= r_shift;
  end

  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_level <= '0;
      r_fe    <= 1'b0;
      r_pe    <= 1'b0;
      r_ov    <= 1'b0;
    end else begin
      if (w_wr)  r_wptr <= r_wptr + 1'b1;
      if (w_pop) r_rptr <= r_rptr + 1'b1;
      unique case ({w_wr, w_pop})
        2'b10:   r_level <= r_level + 1'b1;
        2'b01:   r_level <= r_level - 1'b1;
        default: r_level <= r_level;
      endcase
      r_fe <= w_set_fe | (r_fe & ~bus.err_clr);
      r_pe <= w_set_pe | (r_pe & ~bus.err_clr);
      r_ov <= w_ov     | (r_ov & ~bus.err_clr);
    end
  end

  assign bus.rdata      = w_empty ? '0 : r_mem[r_rptr];
  assign bus.empty      = w_empty;
  assign bus.full       = w_full;
  assign bus.level      = r_level;
  assign bus.frame_err  = r_fe;
  assign bus.parity_err = r_pe;
  assign bus.overrun    = r_ov;
endmodule
